// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the block-RAM port arbiter.
// rr_pick is a cyclic first-one search over up to MAX_REQ requesters.
package ram_arb_pkg;

  localparam int DEFAULT_ADDR_W = 11;
  localparam int DEFAULT_DATA_W = 16;
  localparam int MAX_REQ        = 8;
  localparam int PICK_IDX_W     = 3;

  typedef enum logic {IDLE, OWN} arb_state_e;

  typedef struct packed {
    logic                  found;
    logic [PICK_IDX_W-1:0] idx;
  } pick_t;

  // Walk from the highest offset down, so the candidate nearest to ptr is the one kept
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [PICK_IDX_W-1:0] ptr,
                                    input int n);
    pick_t res;
    int    j;
    res = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (valid[j]) begin
          res.found = 1'b1;
          res.idx   = PICK_IDX_W'(j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_pick.sv
// Cyclic first-one search of width NUM_REQ starting at ptr.
// Thin wrapper that sizes the package search function to this arbiter.
module rr_priority_pick
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);

  pick_t p;

  assign p     = rr_pick(MAX_REQ'(valid), PICK_IDX_W'(ptr), NUM_REQ);
  assign found = p.found;
  assign idx   = IW'(p.idx);

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port among NUM_REQ requesters,
// with bounded bursts per owner and a one-cycle registered response strobe.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_dout
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IW-1:0]    LAST    = IW'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_e         state, stateNext;
  logic [IW-1:0]      ptr, ptrNext, owner, ownerNext, handPtr;
  logic [IW-1:0]      idlePick, handPick, win;
  logic               idleFound, handFound, grant, keep;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic [NUM_REQ-1:0] ownerBit, grantVec;

  assign handPtr  = (owner == LAST) ? '0 : owner + IW'(1);
  assign ownerBit = NUM_REQ'(1) << owner;
  assign keep     = req_valid[owner] &&
                    ((cnt < CNT_MAX) || ((req_valid & ~ownerBit) == '0));
  assign grantVec = grant ? (NUM_REQ'(1) << win) : '0;

  rr_priority_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) uIdlePick (
    .valid(req_valid), .ptr(ptr), .found(idleFound), .idx(idlePick)
  );

  rr_priority_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) uHandPick (
    .valid(req_valid), .ptr(handPtr), .found(handFound), .idx(handPick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      rsp_valid <= '0;
    end else begin
      state     <= stateNext;
      ptr       <= ptrNext;
      owner     <= ownerNext;
      cnt       <= cntNext;
      rsp_valid <= grantVec;
    end
  end

  // Handover picks the next owner in the same cycle so bursts chain without a bubble
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    ownerNext = owner;
    cntNext   = cnt;
    grant     = 1'b0;
    win       = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (idleFound) begin
            grant     = 1'b1;
            win       = idlePick;
            stateNext = OWN;
            ownerNext = idlePick;
            cntNext   = CNT_W'(1);
          end
        end
        OWN: begin
          if (keep) begin
            grant = 1'b1;
            win   = owner;
            if (cnt < CNT_MAX) cntNext = cnt + CNT_W'(1);
          end else begin
            ptrNext = handPtr;
            if (handFound) begin
              grant     = 1'b1;
              win       = handPick;
              ownerNext = handPick;
              cntNext   = CNT_W'(1);
            end else begin
              stateNext = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    req_ready = grantVec;
    ram_en    = grant;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant) begin
      ram_we    = req_we[win];
      ram_addr  = req_addr[int'(win)*ADDR_W +: ADDR_W];
      ram_wdata = req_wdata[int'(win)*DATA_W +: DATA_W];
    end
  end

  assign rsp_rdata = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized scoreboard bench for ram_port_arbiter with a read-first RAM model
// and a behavioural round-robin/burst reference scheduler.
module tb_ram_port_arbiter;

  localparam int N    = 3;
  localparam int AW   = 11;
  localparam int DW   = 16;
  localparam int MAXB = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0, req_we = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0]   rsp_rdata, ram_wdata, ram_dout;
  logic            ram_en, ram_we;
  logic [AW-1:0]   ram_addr;

  always #5 clk = ~clk;

  ram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_dout(ram_dout)
  );

  // Read-first block RAM attached to the arbitrated port
  bit [DW-1:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
  end

  typedef struct {
    int            stamp;
    int            idx;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monE;
  bit [DW-1:0] refMem [0:2047];
  int testsRun = 0, failures = 0, cycleCount = 0;
  int curOwner = -1, runLen = 0, nextStart = 0;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycleCount);
    end
  endtask

  function automatic int pickFrom(input int start, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  // Reference scheduler: who should own the port this cycle, then what it returns
  task automatic checkOutput();
    int            win, others;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    exp_t          e;
    win = -1;
    if (!rst) begin
      if (curOwner >= 0) begin
        others = 0;
        for (int k = 0; k < N; k++) if (k != curOwner && req_valid[k]) others++;
        if (req_valid[curOwner] && (runLen < MAXB || others == 0)) win = curOwner;
        else begin
          nextStart = (curOwner + 1) % N;
          win = pickFrom(nextStart, req_valid);
        end
      end else begin
        win = pickFrom(nextStart, req_valid);
      end
    end
    checkVal("req_ready", 32'(req_ready), (win >= 0) ? (32'd1 << win) : 32'd0);
    checkVal("ram_en", 32'(ram_en), 32'(win >= 0));
    if (win >= 0) begin
      a = req_addr[win*AW +: AW];
      d = req_wdata[win*DW +: DW];
      checkVal("ram_addr", 32'(ram_addr), 32'(a));
      checkVal("ram_we", 32'(ram_we), 32'(req_we[win]));
      checkVal("ram_wdata", 32'(ram_wdata), 32'(d));
      e.stamp = cycleCount;
      e.idx   = win;
      e.rdata = refMem[a];
      expQ.push_back(e);
      if (req_we[win]) refMem[a] = d;
      runLen   = (win == curOwner) ? runLen + 1 : 1;
      curOwner = win;
    end else begin
      checkVal("ram_idle_we", 32'(ram_we), 32'd0);
      checkVal("ram_idle_addr", 32'(ram_addr), 32'd0);
      checkVal("ram_idle_wdata", 32'(ram_wdata), 32'd0);
      curOwner = -1;
    end
    if (rst) begin
      curOwner  = -1;
      runLen    = 0;
      nextStart = 0;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic [N-1:0] w,
                               input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_we    = w;
    req_addr  = a;
    req_wdata = d;
    #2;
    checkOutput();
  endtask

  task automatic randomCycle(input int validPct, input logic [N-1:0] mask);
    logic [N-1:0]    v, w;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) begin
      v[i] = ($urandom_range(99) < validPct) && mask[i];
      w[i] = $urandom_range(1) == 1;
      a[i*AW +: AW] = AW'($urandom_range(31));
      d[i*DW +: DW] = DW'($urandom);
    end
    applyStimulus(1'b0, v, w, a, d);
  endtask

  // Monitor: every response strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (expQ.size() == 0 || expQ[0].stamp != cycleCount - 1) begin
        testsRun++;
        failures++;
        $display("[TB] FAIL spurious_rsp: got rsp_valid %0h, expected none (cycle %0d)", rsp_valid, cycleCount);
      end else begin
        monE = expQ.pop_front();
        checkVal("rsp_valid", 32'(rsp_valid), 32'd1 << monE.idx);
        checkVal("rsp_rdata", 32'(rsp_rdata), 32'(monE.rdata));
      end
    end else if (expQ.size() > 0 && expQ[0].stamp < cycleCount) begin
      monE = expQ.pop_front();
      testsRun++;
      failures++;
      $display("[TB] FAIL missing_rsp: got rsp_valid 0, expected %0h (cycle %0d)", 32'd1 << monE.idx, cycleCount);
    end
  end

  initial begin
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;

    repeat (3) applyStimulus(1'b1, '0, '0, '0, '0);
    applyStimulus(1'b1, '1, '0, '0, '0);
    applyStimulus(1'b0, '0, '0, '0, '0);
    checkVal("rsp_after_reset", 32'(rsp_valid), 32'd0);

    // Single read on requester 0 after seeding 0x123
    a = '0; d = '0;
    a[0*AW +: AW] = 11'h123; d[0*DW +: DW] = 16'hBEEF;
    applyStimulus(1'b0, 3'b001, 3'b001, a, d);
    applyStimulus(1'b0, 3'b001, 3'b000, a, '0);
    applyStimulus(1'b0, '0, '0, '0, '0);

    // Read-first write on requester 1
    a = '0; d = '0;
    a[1*AW +: AW] = 11'h010; d[1*DW +: DW] = 16'h1111;
    applyStimulus(1'b0, 3'b010, 3'b010, a, d);
    d[1*DW +: DW] = 16'h2222;
    applyStimulus(1'b0, 3'b010, 3'b010, a, d);
    applyStimulus(1'b0, 3'b010, 3'b000, a, '0);
    applyStimulus(1'b0, '0, '0, '0, '0);

    // Everyone valid: bursts of MAXB rotate with no idle cycles
    repeat (24) randomCycle(100, '1);

    // Lone owner holds the port, then the others join
    repeat (10) randomCycle(100, 3'b010);
    repeat (8) randomCycle(100, '1);

    // Reset right after an accepted read
    a = '0;
    a[2*AW +: AW] = 11'h123;
    applyStimulus(1'b0, 3'b100, 3'b000, a, '0);
    applyStimulus(1'b1, '0, '0, '0, '0);
    applyStimulus(1'b0, '1, '0, '0, '0);
    checkVal("rsp_dropped_by_reset", 32'(rsp_valid), 32'd0);

    for (int p = 0; p < 8; p++) begin
      repeat (50) randomCycle(20 + 10 * p, '1);
    end

    repeat (3) applyStimulus(1'b0, '0, '0, '0, '0);
    checkVal("queue_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter sharing one port of the 2048x16 dual-port block RAM between NUM_REQ requesters.
- Each requester has a valid/ready request channel and a response channel. The arbiter drives the RAM port signals (en/we/addr/wdata) and routes the RAM read data back to the granted requester one cycle later.
- A bounded burst grant keeps back-to-back beats from one requester on the RAM port, with no starvation of the others.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_W, 11: RAM address width.
- DATA_W, 16: RAM data width.
- MAX_BURST, 4: maximum consecutive accepted beats for one owner while others wait (>=1).

Ports:
- clk, input, 1: single clock.
- rst, input, 1: synchronous reset, active-high.
- req_valid, input, NUM_REQ: per-requester request valid.
- req_ready, output, NUM_REQ: per-requester accept; one-hot or zero.
- req_we, input, NUM_REQ: 1 = write, 0 = read.
- req_addr, input, NUM_REQ*ADDR_W: flattened addresses; requester i is at [i*ADDR_W +: ADDR_W].
- req_wdata, input, NUM_REQ*DATA_W: flattened write data.
- rsp_valid, output, NUM_REQ: one-hot response strobe.
- rsp_rdata, output, DATA_W: read data, shared by all requesters; qualified by rsp_valid.
- ram_en, output, 1: RAM port enable.
- ram_we, output, 1: RAM port write enable.
- ram_addr, output, ADDR_W: RAM port address.
- ram_wdata, output, DATA_W: RAM port write data.
- ram_dout, input, DATA_W: RAM port registered read data.

Behaviour:
- **Interface:** one clock; reset is synchronous and active-high.
- **Reset values:**
  - req_ready = 0, rsp_valid = 0.
  - ram_en = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.
  - Priority pointer = 0, burst counter = 0, state = IDLE.
- **Handshake:** a beat is accepted in cycle T when req_valid[i] & req_ready[i].
  - req_ready is combinational from req_valid and the arbiter state.
  - At most one bit of req_ready is set.
  - req_ready is never asserted without the matching valid.
- **RAM drive:** combinational from the winner in cycle T.
  - ram_en = any grant; ram_we = req_we[win]; ram_addr/ram_wdata = the winner's slice.
  - With no grant: ram_en = 0, ram_we = 0; addr/wdata hold 0.
- **Latency:** 1 cycle.
  - rsp_valid[win] is registered and high in cycle T+1 for both reads and writes.
  - rsp_rdata = ram_dout passthrough in T+1.
  - Writes return the old memory content, because the RAM port is read-first.
- **Throughput:** one beat per cycle, fully pipelined; a new grant in T+1 overlaps the response for T.
- **State machine:**
  - IDLE (no owner):
    - The winner is the first valid requester at or after ptr, searching cyclically.
    - On acceptance: owner = win, cnt = 1, go to OWN.
  - OWN:
    - If req_valid[owner] and (cnt < MAX_BURST or no other valid), grant the owner; cnt saturates at MAX_BURST.
    - Otherwise: ptr = owner+1 mod NUM_REQ, and a new winner is chosen by round-robin from the new ptr in the same cycle, so there is no bubble. If there is a winner, owner = win and cnt = 1; if none, go to IDLE.
  - A lone requester holds the port indefinitely.
- **Boundary conditions:**
  - Pointer wraps from NUM_REQ-1 to 0.
  - If all valids drop, go to IDLE with ptr = owner+1.
  - Simultaneous valids in IDLE: the lowest index at or after ptr wins.
  - req_valid deasserted without acceptance is legal (no request is lost); address and data are only sampled on acceptance.
- **Reset mid-operation:** an in-flight response is dropped, so rsp_valid = 0 in the cycle after rst; all state returns to its reset value.

Decomposition:
- Shared package ram_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - State enum (IDLE, OWN).
  - Function rr_pick(valid, ptr), returning the index plus a found flag.
- Sub-module rr_priority_pick: combinational cyclic first-one search from a pointer, of width NUM_REQ.
- The top level holds the FSM, burst counter, response register and mux.

Test Plan:
- Single read: after writing addr 0x123 = 0xBEEF, req0 read 0x123 → req_ready[0] in T, rsp_valid = 01 in T+1, rsp_rdata = 0xBEEF.
- Write read-first: mem[0x010] = 0x1111, req1 writes 0x2222 to 0x010 → rsp_valid[1] in T+1 with rdata 0x1111; a subsequent read returns 0x2222.
- Burst fairness: NUM_REQ=2, MAX_BURST=4, both valid continuously → grant sequence 0,0,0,0,1,1,1,1,0… with no idle cycles; responses follow one cycle later.
- Lone owner: only req1 valid for 10 cycles → 10 consecutive grants to req1 with cnt saturated; req0 asserts at cycle 10 and is granted by cycle 11.
- Wrap/priority: NUM_REQ=4, ptr=3, valids 1011 → requester 3 wins; next handover goes to 0 then 1, skipping 2.
- Reset mid-operation: rst asserted in the cycle after a read acceptance → rsp_valid = 0 and ram_en = 0 next cycle; after release, grants start from requester 0.
